fxp_mult_pipe: RTL and testbench

Pipelined, parametrised signed fixed-point multiplier with valid/ready flow control, selectable rounding and saturation, and per-result plus sticky overflow flags. It is the streaming successor to the combinational sign-magnitude multiplier. It sits between Kalman-filter matrix datapath stages that exchange Q-format words and can apply backpressure.

---
 rtl/fxp_mult_pipe.sv | 163 ++++++++++++++++
 tb/tb_fxp_mult_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mult_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fxp_mult_pipe                                            |
// | Description : Pipelined signed fixed-point multiplier (Q-format) with  |
// |               valid/ready flow control, selectable round-half-away /   |
// |               truncate, saturate / wrap, per-result and sticky         |
// |               overflow flags.                                          |
// | Revision    : 1.0 - initial streaming implementation                   |
// +------------------------------------------------------------------------+
module fxp_mult_pipe #(
   parameter int N     = 32,
   parameter int Q     = 18,
   parameter int ROUND = 1,
   parameter int SAT   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_ovr,
   output logic         ovr_sticky,
   input  logic         clr_ovr
);

   // Result magnitude width and the shifted-product width that keeps the
   // rounding bit as its LSB.
   localparam int c_mag_w = 2 * N - Q;
   localparam int c_shf_w = 2 * N - Q + 1;

   // Largest magnitudes representable for a positive / negative result.
   localparam logic [c_mag_w-1:0] c_lim_pos = {{(c_mag_w - N){1'b0}}, 1'b0, {(N - 1){1'b1}}};
   localparam logic [c_mag_w-1:0] c_lim_neg = {{(c_mag_w - N){1'b0}}, 1'b1, {(N - 1){1'b0}}};
   localparam logic [N-1:0]       c_sat_pos = {1'b0, {(N - 1){1'b1}}};
   localparam logic [N-1:0]       c_sat_neg = {1'b1, {(N - 1){1'b0}}};

   // Pipeline registers
   logic                 r_s1_valid;
   logic                 r_s1_sign;
   logic [N-1:0]         r_s1_mag_a;
   logic [N-1:0]         r_s1_mag_b;
   logic                 r_s2_valid;
   logic                 r_s2_sign;
   logic [2*N-1:0]       r_s2_prod;
   logic                 r_s3_valid;
   logic                 r_s3_sign;
   logic [c_mag_w-1:0]   r_s3_mag;
   logic                 r_out_valid;
   logic [N-1:0]         r_out_data;
   logic                 r_out_ovr;
   logic                 r_ovr_sticky;

   // Combinational helpers
   logic                 w_stall;
   logic [N-1:0]         w_mag_a;
   logic [N-1:0]         w_mag_b;
   logic [c_shf_w-1:0]   w_shifted;
   logic                 w_rnd_bit;
   logic [c_mag_w-1:0]   w_mag;
   logic                 w_ovr;
   logic [N-1:0]         w_mag_low;
   logic [N-1:0]         w_wrap;
   logic [N-1:0]         w_result;

   // The whole pipe freezes while a result waits for the consumer; no
   // bubble collapsing, so in_ready depends combinationally on out_ready.
   assign w_stall  = r_out_valid & ~out_ready;
   assign in_ready = ~w_stall;

   // Unsigned magnitudes; the most negative value maps to 2^(N-1) exactly.
   assign w_mag_a = in_a[N-1] ? -in_a : in_a;
   assign w_mag_b = in_b[N-1] ? -in_b : in_b;

   // Drop the fraction bits below Q-1; bit 0 of the shifted value is P[Q-1].
   assign w_shifted = c_shf_w'(r_s2_prod >> (Q - 1));
   assign w_rnd_bit = (ROUND != 0) & w_shifted[0];
   // No carry out possible: |P| <= 2^(2N-2), so M stays far below all-ones.
   assign w_mag     = w_shifted[c_shf_w-1:1] + {{(c_mag_w - 1){1'b0}}, w_rnd_bit};

   // Overflow and final sign application on the registered magnitude.
   assign w_ovr     = r_s3_sign ? (r_s3_mag > c_lim_neg) : (r_s3_mag > c_lim_pos);
   assign w_mag_low = r_s3_mag[N-1:0];
   assign w_wrap    = r_s3_sign ? -w_mag_low : w_mag_low;
   assign w_result  = ((SAT != 0) && w_ovr) ? (r_s3_sign ? c_sat_neg : c_sat_pos) : w_wrap;

   // S1: capture product sign and operand magnitudes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_mag_a <= '0;
         r_s1_mag_b <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= in_valid;
         r_s1_sign  <= in_a[N-1] ^ in_b[N-1];
         r_s1_mag_a <= w_mag_a;
         r_s1_mag_b <= w_mag_b;
      end
   end

   // S2: full-width unsigned product of the magnitudes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_sign  <= 1'b0;
         r_s2_prod  <= '0;
      end else if (!w_stall) begin
         r_s2_valid <= r_s1_valid;
         r_s2_sign  <= r_s1_sign;
         r_s2_prod  <= {{N{1'b0}}, r_s1_mag_a} * {{N{1'b0}}, r_s1_mag_b};
      end
   end

   // S3: rescaled (and optionally rounded) result magnitude.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s3_valid <= 1'b0;
         r_s3_sign  <= 1'b0;
         r_s3_mag   <= '0;
      end else if (!w_stall) begin
         r_s3_valid <= r_s2_valid;
         r_s3_sign  <= r_s2_sign;
         r_s3_mag   <= w_mag;
      end
   end

   // Output register: data and flag keep their last value when no result loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovr   <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= r_s3_valid;
         if (r_s3_valid) begin
            r_out_data <= w_result;
            r_out_ovr  <= w_ovr;
         end
      end
   end

   // Sticky overflow: a new overflowing result beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovr_sticky <= 1'b0;
      end else if (!w_stall && r_s3_valid && w_ovr) begin
         r_ovr_sticky <= 1'b1;
      end else if (clr_ovr) begin
         r_ovr_sticky <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_ovr    = r_out_ovr;
   assign ovr_sticky = r_ovr_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fxp_mult_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_fxp_mult_pipe                                         |
// | Description : Self-checking bench for fxp_mult_pipe: directed vector   |
// |               table, sticky/backpressure/reset sequences and a random  |
// |               sweep of several N/Q/ROUND/SAT variants against a model. |
// | Revision    : 1.0 - initial bench                                      |
// +------------------------------------------------------------------------+
module tb_fxp_mult_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_checks    = 0;
   int   n_fail      = 0;
   int   n_out_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: exact signed product, magnitude rescaled by 2^-Q, then the
   // rounding / overflow / saturation rules. Returns {ovr, data[31:0]}.
   function automatic logic [32:0] model(input int n, input int q, input int rnd,
                                         input int sat, input longint a, input longint b);
      longint          p;
      longint unsigned mag, m, half, res;
      logic            neg, ovr;
      p    = a * b;
      neg  = (p < 0);
      mag  = neg ? longint'(-p) : longint'(p);
      m    = mag >> q;
      if (rnd != 0) m = m + ((mag >> (q - 1)) & 64'd1);
      half = 64'd1 << (n - 1);
      ovr  = neg ? (m > half) : (m > half - 1);
      if (sat != 0 && ovr) res = neg ? (64'd0 - half) : (half - 1);
      else                 res = neg ? (64'd0 - m) : m;
      return {ovr, res[31:0]};
   endfunction

   // Operand picker: corner values for width n or a raw random word.
   function automatic logic [31:0] pick(input int n, input logic [3:0] kind, input logic [31:0] raw);
      longint unsigned half;
      logic [63:0]     v;
      half = 64'd1 << (n - 1);
      case (kind)
         4'd0:    v = 64'd0;
         4'd1:    v = half - 1;
         4'd2:    v = 64'd0 - half;
         4'd3:    v = 64'd0 - (half - 1);
         4'd4:    v = 64'd1;
         4'd5:    v = '1;
         default: v = {32'd0, raw};
      endcase
      return v[31:0];
   endfunction

   // ---------------- directed instances (N=32, Q=18) ----------------
   logic        d_valid, d_ready, d_clr;
   logic [31:0] d_a, d_b;
   logic        ra_ir, ra_ov, ra_oo, ra_os;
   logic [31:0] ra_od;
   logic        tw_ir, tw_ov, tw_oo, tw_os;
   logic [31:0] tw_od;

   fxp_mult_pipe #(.N(32), .Q(18), .ROUND(1), .SAT(1)) u_dut_rs (
      .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(ra_ir),
      .in_a(d_a), .in_b(d_b), .out_valid(ra_ov), .out_ready(d_ready),
      .out_data(ra_od), .out_ovr(ra_oo), .ovr_sticky(ra_os), .clr_ovr(d_clr)
   );

   fxp_mult_pipe #(.N(32), .Q(18), .ROUND(0), .SAT(0)) u_dut_tw (
      .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(tw_ir),
      .in_a(d_a), .in_b(d_b), .out_valid(tw_ov), .out_ready(d_ready),
      .out_data(tw_od), .out_ovr(tw_oo), .ovr_sticky(tw_os), .clr_ovr(d_clr)
   );

   // ---------------- random sweep instances ----------------
   logic        s_valid, s_ready;
   logic [3:0]  s_ka, s_kb;
   logic [31:0] s_ra, s_rb;
   logic [11:0] sw_ir;

   for (genvar g = 0; g < 12; g++) begin : g_sw
      localparam int SN = (g < 4) ? 32 : ((g < 8) ? 16 : 24);
      localparam int SQ = (g < 4) ? 18 : ((g < 8) ? 8 : 12);
      localparam int SR = g % 2;
      localparam int SS = (g / 2) % 2;

      logic [31:0]   a32, b32;
      logic [SN-1:0] a, b, od, p_d;
      logic          ir, ov, oo, os, p_v, p_r, p_o;
      logic [32:0]   q[$];

      assign a32 = pick(SN, s_ka, s_ra);
      assign b32 = pick(SN, s_kb, s_rb);
      assign a   = a32[SN-1:0];
      assign b   = b32[SN-1:0];
      assign sw_ir[g] = ir;

      fxp_mult_pipe #(.N(SN), .Q(SQ), .ROUND(SR), .SAT(SS)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(ir),
         .in_a(a), .in_b(b), .out_valid(ov), .out_ready(s_ready),
         .out_data(od), .out_ovr(oo), .ovr_sticky(os), .clr_ovr(1'b0)
      );

      // Scoreboard: inputs change just after posedge, so at negedge the
      // values seen are exactly those the next rising edge will act on.
      always @(negedge clk) begin
         logic [32:0] e;
         if (!rst_n) begin
            q.delete();
            p_v = 1'b0;
         end else begin
            check($sformatf("sw%0d_in_ready", g), ir, !(ov && !s_ready));
            if (p_v && !p_r) begin
               check($sformatf("sw%0d_stall_valid", g), ov, 1'b1);
               check($sformatf("sw%0d_stall_data", g), od, p_d);
               check($sformatf("sw%0d_stall_ovr", g), oo, p_o);
            end
            if (ov && s_ready) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sw%0d_spurious: got output 0x%0h, expected no output", g, od);
               end else begin
                  e = q.pop_front();
                  check($sformatf("sw%0d_data", g), od, e[SN-1:0]);
                  check($sformatf("sw%0d_ovr", g), oo, e[32]);
                  n_out_total++;
               end
            end
            if (s_valid && ir)
               q.push_back(model(SN, SQ, SR, SS, longint'($signed(a)), longint'($signed(b))));
            p_v = ov;
            p_r = s_ready;
            p_d = od;
            p_o = oo;
         end
      end
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rs;
      logic        ors;
      logic [31:0] tw;
      logic        otw;
   } vec_t;

   vec_t vecs[11];

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      @(negedge clk);
      d_a = v.a; d_b = v.b; d_valid = 1'b1; d_ready = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", idx), ra_ir, 1'b1);
      @(negedge clk);
      d_valid = 1'b0;
      lat = 0;
      while (!ra_ov && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("v%0d_latency", idx), lat, 3);
      check($sformatf("v%0d_rs_data", idx), ra_od, v.rs);
      check($sformatf("v%0d_rs_ovr", idx), ra_oo, v.ors);
      check($sformatf("v%0d_tw_valid", idx), tw_ov, 1'b1);
      check($sformatf("v%0d_tw_data", idx), tw_od, v.tw);
      check($sformatf("v%0d_tw_ovr", idx), tw_oo, v.otw);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected end of test");
      $fatal(1, "time limit reached");
   end

   initial begin
      int sent, got, accepted;

      //            a             b             R1S1 data     ovr   R0S0 data     ovr
      vecs[0]  = '{32'h00060000, 32'h00080000, 32'h000C0000, 1'b0, 32'h000C0000, 1'b0};
      vecs[1]  = '{32'hFFFA0000, 32'h00080000, 32'hFFF40000, 1'b0, 32'hFFF40000, 1'b0};
      vecs[2]  = '{32'h40000000, 32'h00080000, 32'h7FFFFFFF, 1'b1, 32'h80000000, 1'b1};
      vecs[3]  = '{32'hC0000000, 32'h00080000, 32'h80000000, 1'b0, 32'h80000000, 1'b0};
      vecs[4]  = '{32'h00000001, 32'h00020000, 32'h00000001, 1'b0, 32'h00000000, 1'b0};
      vecs[5]  = '{32'hFFFFFFFF, 32'h00020000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
      vecs[6]  = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1};
      vecs[7]  = '{32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
      vecs[8]  = '{32'h7FFFFFFF, 32'h00040000, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0};
      vecs[9]  = '{32'hFFFFFFFF, 32'h00010000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
      vecs[10] = '{32'h00000003, 32'h00020000, 32'h00000002, 1'b0, 32'h00000001, 1'b0};

      rst_n = 1'b0;
      d_valid = 1'b0; d_ready = 1'b1; d_clr = 1'b0; d_a = '0; d_b = '0;
      s_valid = 1'b0; s_ready = 1'b1; s_ka = '0; s_kb = '0; s_ra = '0; s_rb = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", ra_ov, 1'b0);
      check("rst_out_data", ra_od, 32'h0);
      check("rst_out_ovr", ra_oo, 1'b0);
      check("rst_sticky", ra_os, 1'b0);
      check("rst_in_ready", ra_ir, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Sticky flag: set by earlier overflow, plain clear, then clear racing a new overflow
      check("sticky_rs_set", ra_os, 1'b1);
      check("sticky_tw_set", tw_os, 1'b1);
      @(negedge clk); d_clr = 1'b1;
      @(negedge clk); d_clr = 1'b0;
      check("sticky_rs_clr", ra_os, 1'b0);
      check("sticky_tw_clr", tw_os, 1'b0);
      @(negedge clk);
      d_a = 32'h40000000; d_b = 32'h00080000; d_valid = 1'b1;
      @(negedge clk); d_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); d_clr = 1'b1;
      check("sticky_pre_race", ra_os, 1'b0);
      @(negedge clk); d_clr = 1'b0;
      check("race_out_valid", ra_ov, 1'b1);
      check("race_out_ovr", ra_oo, 1'b1);
      check("race_sticky_rs", ra_os, 1'b1);
      check("race_sticky_tw", tw_os, 1'b1);
      @(negedge clk);

      // Backpressure: fill the pipe against a blocked consumer, then drain in order
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         d_ready = (cyc >= 8);
         d_valid = (sent < 6);
         d_a     = 32'((sent + 1) << 18);
         d_b     = 32'h00040000;
         #1;
         if (cyc == 7) begin
            check("bp_accepted_at_stall", sent, 4);
            check("bp_in_ready_low", ra_ir, 1'b0);
            check("bp_held_data", ra_od, 32'h00040000);
         end
         if (ra_ov && d_ready) begin
            check($sformatf("bp_out%0d", got), ra_od, 32'((got + 1) << 18));
            got++;
         end
         if (d_valid && ra_ir) sent++;
      end
      d_valid = 1'b0; d_ready = 1'b1;
      check("bp_out_count", got, 6);

      // Reset mid-stream with items in flight
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         d_valid = 1'b1;
         d_a = (i == 0) ? 32'h40000000 : 32'(i << 18);
         d_b = (i == 0) ? 32'h00080000 : 32'h00040000;
      end
      @(negedge clk);
      d_valid = 1'b0;
      check("mid_pre_valid", ra_ov, 1'b1);
      check("mid_pre_data", ra_od, 32'h7FFFFFFF);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", ra_ov, 1'b0);
      check("mid_rst_data", ra_od, 32'h0);
      check("mid_rst_ovr", ra_oo, 1'b0);
      check("mid_rst_sticky", ra_os, 1'b0);
      check("mid_rst_in_ready", ra_ir, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("mid_no_stale%0d", i), ra_ov, 1'b0);
      end
      run_vec(100, vecs[0]);
      @(negedge clk);

      // Random sweep over all configurations with random backpressure
      accepted = 0;
      for (int cyc = 0; cyc < 30000 && accepted < 1000; cyc++) begin
         @(posedge clk);
         #1;
         s_ready = ($urandom_range(0, 3) != 0);
         s_valid = ($urandom_range(0, 7) != 0);
         s_ka    = 4'($urandom_range(0, 15));
         s_kb    = 4'($urandom_range(0, 15));
         s_ra    = $urandom;
         s_rb    = $urandom;
         #1;
         if (s_valid && sw_ir[0]) accepted++;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("sweep_accepted", accepted, 1000);
      check("sweep_results", n_out_total, 12 * 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
